// File: rtl/demux_1to5_32bits_reg_pkg.sv
// Shared constants, select encodings and the select-legality helper for the
// registered 1-to-5 result demultiplexer.
package demux_1to5_32bits_reg_pkg;

    // Data path width and number of destination channels.
    localparam int DEMUX_W = 32;
    localparam int DEMUX_N = 5;

    // Width of the destination select field.
    localparam int SEL_W = 3;

    // Destination select encodings; codes above SEL_CH4 are illegal.
    typedef enum logic [SEL_W-1:0] {
        SEL_CH0 = 3'b000,
        SEL_CH1 = 3'b001,
        SEL_CH2 = 3'b010,
        SEL_CH3 = 3'b011,
        SEL_CH4 = 3'b100
    } demux_sel_e;

    // A select addresses a real channel only up to and including SEL_CH4.
    function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel);
        return (sel <= SEL_CH4);
    endfunction

endpackage : demux_1to5_32bits_reg_pkg

// File: rtl/demux_1to5_32bits_reg_reg_32bits_ld.sv
// 32-bit holding register with synchronous active-high reset and a load
// enable. Reset takes priority over load.
module reg_32bits_ld
    import demux_1to5_32bits_reg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ld,
    input  logic [DEMUX_W-1:0] d,
    output logic [DEMUX_W-1:0] q
);

    logic [DEMUX_W-1:0] data_q;
    logic [DEMUX_W-1:0] data_d;

    // Next value: capture d on load, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (ld) begin
            data_d = d;
        end
    end

    // State register; reset clears the held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : reg_32bits_ld

// File: rtl/demux_1to5_32bits_reg.sv
// Registered 1-to-5 demultiplexer: steers the 32-bit result bus into one of
// five holding registers, tracks per-channel valid flags that consumers
// clear, remembers the last legal destination and pulses Err on a load to an
// illegal select code.
module demux_1to5_32bits_reg
    import demux_1to5_32bits_reg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [DEMUX_W-1:0] D,
    input  logic [SEL_W-1:0]   Select,
    input  logic               Load,
    input  logic [DEMUX_N-1:0] Clear,
    output logic [DEMUX_W-1:0] O0,
    output logic [DEMUX_W-1:0] O1,
    output logic [DEMUX_W-1:0] O2,
    output logic [DEMUX_W-1:0] O3,
    output logic [DEMUX_W-1:0] O4,
    output logic [DEMUX_N-1:0] V,
    output logic [SEL_W-1:0]   Last,
    output logic               Err
);

    // A load is accepted only when the select names a real channel.
    logic               sel_legal;
    logic               load_ok;
    logic [DEMUX_N-1:0] wr_onehot;

    assign sel_legal = sel_is_legal(Select);
    assign load_ok   = Load && sel_legal;

    // Per-channel holding registers, one write enable each.
    logic [DEMUX_W-1:0] ch_q [DEMUX_N];

    genvar gi;
    generate
        for (gi = 0; gi < DEMUX_N; gi++) begin : g_ch
            // One-hot decode of the select into a write strobe.
            assign wr_onehot[gi] = load_ok && (Select == SEL_W'(gi));

            reg_32bits_ld u_reg (
                .clk   (clk),
                .reset (reset),
                .ld    (wr_onehot[gi]),
                .d     (D),
                .q     (ch_q[gi])
            );
        end
    endgenerate

    assign O0 = ch_q[0];
    assign O1 = ch_q[1];
    assign O2 = ch_q[2];
    assign O3 = ch_q[3];
    assign O4 = ch_q[4];

    // Status state.
    logic [DEMUX_N-1:0] v_q;
    logic [DEMUX_N-1:0] v_d;
    logic [SEL_W-1:0]   last_q;
    logic [SEL_W-1:0]   last_d;
    logic               err_q;
    logic               err_d;

    // Next status: clears drop valid bits first, then the write strobe sets
    // its bit so a load beats a clear on the same channel. Err is high only
    // for the cycle after an illegal-select load.
    always_comb begin
        v_d    = (v_q & ~Clear) | wr_onehot;
        last_d = last_q;
        err_d  = Load && !sel_legal;
        if (load_ok) begin
            last_d = Select;
        end
    end

    // Status registers; reset discards any same-cycle load or clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q    <= '0;
            last_q <= SEL_CH0;
            err_q  <= 1'b0;
        end else begin
            v_q    <= v_d;
            last_q <= last_d;
            err_q  <= err_d;
        end
    end

    assign V    = v_q;
    assign Last = last_q;
    assign Err  = err_q;

endmodule : demux_1to5_32bits_reg
